// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide over magnitudes, with sign fix-up before write-back.
module mul_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] mq, mq_n;
    logic [WIDTH-1:0] opb, opb_n;
    logic [WIDTH-1:0] orig_a, orig_a_n;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic             is_div, is_div_n;
    logic             neg_q, neg_q_n;
    logic             neg_r, neg_r_n;
    logic             div_zero, div_zero_n;
    logic             busy_n, done_n;

    // Operand magnitudes for the signed ops, formed at latch time
    logic             is_signed, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign is_signed = ~op[0];
    assign sa        = is_signed & busA[WIDTH-1];
    assign sb        = is_signed & busB[WIDTH-1];
    assign mag_a     = sa ? WIDTH'(-busA) : busA;
    assign mag_b     = sb ? WIDTH'(-busB) : busB;

    // One iteration of each algorithm on WIDTH+1-bit accumulators
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [PW-1:0]    prod, prod_fix;
    assign mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
    assign div_shift = {acc, mq[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign prod      = {acc, mq};
    assign prod_fix  = neg_q ? PW'(-prod) : prod;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        acc_n      = acc;
        mq_n       = mq;
        opb_n      = opb;
        orig_a_n   = orig_a;
        is_div_n   = is_div;
        neg_q_n    = neg_q;
        neg_r_n    = neg_r;
        div_zero_n = div_zero;
        hi_n       = hi;
        lo_n       = lo;
        busy_n     = busy;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (start) begin
                    state_n    = CALC;
                    busy_n     = 1'b1;
                    cnt_n      = '0;
                    acc_n      = '0;
                    mq_n       = mag_a;
                    opb_n      = mag_b;
                    orig_a_n   = busA;
                    is_div_n   = op[1];
                    neg_q_n    = sa ^ sb;
                    neg_r_n    = sa;
                    div_zero_n = (busB == '0);
                end else begin
                    if (mthi) hi_n = busA;
                    if (mtlo) lo_n = busA;
                end
            end
            CALC: begin
                busy_n = 1'b1;
                if (is_div) begin
                    if (div_diff[WIDTH]) begin
                        acc_n = div_shift[WIDTH-1:0];
                        mq_n  = {mq[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_n = div_diff[WIDTH-1:0];
                        mq_n  = {mq[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_n = mul_sum[WIDTH:1];
                    mq_n  = {mul_sum[0], mq[WIDTH-1:1]};
                end
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_n = FIX;
                    cnt_n   = '0;
                end
            end
            FIX: begin
                // Result lands in HI/LO on entry to DONE so it is visible with the done pulse
                busy_n  = 1'b1;
                done_n  = 1'b1;
                state_n = DONE;
                if (is_div) begin
                    if (div_zero) begin
                        lo_n = '1;
                        hi_n = orig_a;
                    end else begin
                        lo_n = neg_q ? WIDTH'(-mq) : mq;
                        hi_n = neg_r ? WIDTH'(-acc) : acc;
                    end
                end else begin
                    {hi_n, lo_n} = prod_fix;
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            opb      <= '0;
            orig_a   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            cnt      <= cnt_n;
            acc      <= acc_n;
            mq       <= mq_n;
            opb      <= opb_n;
            orig_a   <= orig_a_n;
            is_div   <= is_div_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            div_zero <= div_zero_n;
            hi       <= hi_n;
            lo       <= lo_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: issued ops push expected {hi,lo} and done cycle,
// a monitor pops on every done pulse and checks result, latency and busy length.
module tb_mul_div_unit;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clock, reset, start, mthi, mtlo;
    logic [1:0]    op;
    logic [W-1:0]  busA, busB, hi, lo;
    logic          busy, done;

    mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .busA(busA), .busB(busB), .mthi(mthi), .mtlo(mtlo),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            busy_run = 0;
    logic [63:0]   exp_q[$];
    int            t_q[$];
    logic [W-1:0]  m_hi = '0, m_lo = '0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain integer arithmetic with MIPS divide-by-zero rule
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = $signed(a);
        sb = $signed(b);
        res = '0;
        case (o)
            2'd0: res = 64'(sa * sb);
            2'd1: res = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else        res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 32'h8000_0000;
            3: v = W'($urandom_range(0, 20));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // Monitor: sampled just after the active edge
    always @(posedge clock) begin
        #1;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    logic [63:0] e;
                    int t;
                    e = exp_q.pop_front();
                    t = t_q.pop_front();
                    chk("result_hilo", {hi, lo}, e);
                    chk("done_latency", 64'(cyc), 64'(t + LAT));
                    m_hi = e[63:32];
                    m_lo = e[31:0];
                end
            end
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                chk("busy_length", 64'(busy_run), 64'(LAT));
                busy_run = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (busy && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    // Returns at the negedge of the first busy cycle
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic with_mthi);
        wait_idle();
        start = 1'b1; op = o; busA = a; busB = b; mthi = with_mthi;
        exp_q.push_back(model(o, a, b));
        t_q.push_back(cyc);
        @(negedge clock);
        start = 1'b0; mthi = 1'b0;
    endtask

    task automatic mt_write(input logic wh, input logic wl, input logic [W-1:0] a);
        wait_idle();
        mthi = wh; mtlo = wl; busA = a;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0;
        if (wh) m_hi = a;
        if (wl) m_lo = a;
        chk("mt_hi", 64'(hi), 64'(m_hi));
        chk("mt_lo", 64'(lo), 64'(m_lo));
        chk("mt_no_done", 64'(done), 64'd0);
    endtask

    initial begin
        int dc;
        logic [W-1:0] hold;
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = '0; busA = '0; busB = '0;
        repeat (3) @(negedge clock);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        reset = 1'b0;

        // Reset during CALC discards the operation
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midreset_hilo", {hi, lo}, 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        exp_q.delete();
        t_q.delete();
        m_hi = '0; m_lo = '0;
        dc = done_cnt;
        repeat (40) @(negedge clock);
        chk("midreset_no_done", 64'(done_cnt), 64'(dc));

        // Directed corner operations
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(2'd3, 32'd100, 32'd0, 1'b0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);

        // mthi and a second start during CALC are ignored
        do_op(2'd1, 32'd5, 32'd6, 1'b0);
        repeat (3) @(negedge clock);
        hold = m_hi;
        busA = 32'h1234; mthi = 1'b1; start = 1'b1; op = 2'd3; busB = 32'd3;
        @(negedge clock);
        mthi = 1'b0; start = 1'b0;
        chk("busy_mthi_ignored", 64'(hi), 64'(hold));
        chk("busy_still_high", 64'(busy), 64'd1);

        // start and mthi in the same idle cycle: the write is dropped
        wait_idle();
        hold = m_hi;
        do_op(2'd3, 32'd1000, 32'd7, 1'b1);
        chk("start_beats_mthi", 64'(hi), 64'(hold));

        mt_write(1'b0, 1'b1, 32'h0000_CAFE);
        mt_write(1'b1, 1'b1, 32'hDEAD_BEEF);

        // Randomized operations with occasional idle moves
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
            do_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
        end

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 200) begin
                @(negedge clock);
                n++;
            end
            if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        end
        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
